// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU controller and datapath.
// Opcodes, control-word encodings and widths.
package cpu_pkg;

    localparam int DATA_W  = 4;
    localparam int PC_W    = 4;
    localparam int NREG    = 16;
    localparam int INSTR_W = 8;
    localparam int OP_W    = 4;
    localparam int IDX_W   = 4;

    localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0010;
    localparam logic [OP_W-1:0] OP_NOR  = 4'b0011;
    localparam logic [OP_W-1:0] OP_LDR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_STR  = 4'b0101;
    localparam logic [OP_W-1:0] OP_JZR  = 4'b0110;
    localparam logic [OP_W-1:0] OP_JZI  = 4'b0111;
    localparam logic [OP_W-1:0] OP_JCR  = 4'b1000;
    localparam logic [OP_W-1:0] OP_JCI  = 4'b1010;
    localparam logic [OP_W-1:0] OP_SHR  = 4'b1100;
    localparam logic [OP_W-1:0] OP_LDI  = 4'b1101;
    localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_NOR = 4'b0010;
    localparam logic [3:0] ALU_SHR = 4'b0011;

    localparam logic [1:0] ACC_ALU  = 2'b00;
    localparam logic [1:0] ACC_REG  = 2'b01;
    localparam logic [1:0] ACC_IMM  = 2'b10;
    localparam logic [1:0] ACC_HOLD = 2'b11;

    localparam logic PC_REG = 1'b0;
    localparam logic PC_IMM = 1'b1;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: A is the accumulator, B the selected register.
// carryWe tells the datapath whether this op defines a new carry.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        selAlu,
    output logic [DATA_W-1:0] result,
    output logic              carryOut,
    output logic              carryWe
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    // Operation select; unused codes pass A and leave carry alone
    always_comb begin
        result   = a;
        carryOut = 1'b0;
        carryWe  = 1'b0;
        unique case (selAlu)
            ALU_ADD: begin
                result   = sum[DATA_W-1:0];
                carryOut = sum[DATA_W];
                carryWe  = 1'b1;
            end
            ALU_SUB: begin
                result   = a - b;
                carryOut = (b > a);
                carryWe  = 1'b1;
            end
            ALU_NOR: begin
                result = ~(a | b);
            end
            ALU_SHR: begin
                result   = a >> 1;
                carryOut = a[0];
                carryWe  = 1'b1;
            end
            default: begin
                result = a;
            end
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// Datapath responder: PC, IR, register file, Acc and carry.
// Executes one control word per clock; never stalls.
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic               CLK,
    input  logic               CLB,
    input  logic               LoadIR,
    input  logic               IncPC,
    input  logic               SelPC,
    input  logic               LoadPC,
    input  logic               LoadReg,
    input  logic               LoadAcc,
    input  logic [1:0]         SelAcc,
    input  logic [3:0]         SelALU,
    input  logic [INSTR_W-1:0] InstrData,
    output logic [PC_W-1:0]    PCAddr,
    output logic [OP_W-1:0]    Opcode,
    output logic               Z,
    output logic               C,
    output logic [DATA_W-1:0]  AccOut
);

    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  acc;
    logic               carry;
    logic [DATA_W-1:0]  regFile [NREG];

    logic [IDX_W-1:0]  regIdx;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] regRead;
    logic [DATA_W-1:0] aluResult;
    logic              aluCarry;
    logic              aluCarryWe;

    assign regIdx  = ir[IDX_W-1:0];
    assign imm     = ir[DATA_W-1:0];
    assign regRead = regFile[regIdx];

    cpu_alu uAlu (
        .a        (acc),
        .b        (regRead),
        .selAlu   (SelALU),
        .result   (aluResult),
        .carryOut (aluCarry),
        .carryWe  (aluCarryWe)
    );

    // Program counter: a jump load beats a sequential increment
    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            pc <= '0;
        end else if (LoadPC) begin
            pc <= (SelPC == PC_IMM) ? imm : regRead;
        end else if (IncPC) begin
            pc <= pc + 1'b1;
        end
    end

    // Instruction register; other loads this edge still see the old IR
    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            ir <= '0;
        end else if (LoadIR) begin
            ir <= InstrData;
        end
    end

    // Register file store of the current (pre-edge) accumulator
    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            for (int i = 0; i < NREG; i++) begin
                regFile[i] <= '0;
            end
        end else if (LoadReg) begin
            regFile[regIdx] <= acc;
        end
    end

    // Accumulator load from ALU, register or immediate
    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            acc <= '0;
        end else if (LoadAcc) begin
            unique case (SelAcc)
                ACC_ALU:  acc <= aluResult;
                ACC_REG:  acc <= regRead;
                ACC_IMM:  acc <= imm;
                default:  acc <= acc;
            endcase
        end
    end

    // Carry only changes on an ALU write-back from a carry-defining op
    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            carry <= 1'b0;
        end else if (LoadAcc && SelAcc == ACC_ALU && aluCarryWe) begin
            carry <= aluCarry;
        end
    end

    assign PCAddr = pc;
    assign Opcode = ir[INSTR_W-1:INSTR_W-OP_W];
    assign Z      = (acc == '0);
    assign C      = carry;
    assign AccOut = acc;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed self-checking bench for cpu_datapath.
// Controls change 1ns after a rising edge; outputs sampled there.
module tb_cpu_datapath;

    logic       CLK;
    logic       CLB;
    logic       LoadIR;
    logic       IncPC;
    logic       SelPC;
    logic       LoadPC;
    logic       LoadReg;
    logic       LoadAcc;
    logic [1:0] SelAcc;
    logic [3:0] SelALU;
    logic [7:0] InstrData;
    logic [3:0] PCAddr;
    logic [3:0] Opcode;
    logic       Z;
    logic       C;
    logic [3:0] AccOut;

    int checks = 0;
    int errors = 0;

    cpu_datapath dut (
        .CLK       (CLK),
        .CLB       (CLB),
        .LoadIR    (LoadIR),
        .IncPC     (IncPC),
        .SelPC     (SelPC),
        .LoadPC    (LoadPC),
        .LoadReg   (LoadReg),
        .LoadAcc   (LoadAcc),
        .SelAcc    (SelAcc),
        .SelALU    (SelALU),
        .InstrData (InstrData),
        .PCAddr    (PCAddr),
        .Opcode    (Opcode),
        .Z         (Z),
        .C         (C),
        .AccOut    (AccOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic idle();
        LoadIR  = 1'b0;
        IncPC   = 1'b0;
        SelPC   = 1'b0;
        LoadPC  = 1'b0;
        LoadReg = 1'b0;
        LoadAcc = 1'b0;
        SelAcc  = 2'b11;
        SelALU  = 4'b0111;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic loadIr(input logic [7:0] d);
        InstrData = d;
        LoadIR = 1'b1;
        cyc();
        idle();
    endtask

    task automatic ldi(input logic [3:0] v);
        loadIr({4'hD, v});
        LoadAcc = 1'b1;
        SelAcc = 2'b10;
        cyc();
        idle();
    endtask

    task automatic str(input logic [3:0] n);
        loadIr({4'h5, n});
        LoadReg = 1'b1;
        cyc();
        idle();
    endtask

    task automatic aluOp(input logic [3:0] op);
        LoadAcc = 1'b1;
        SelAcc = 2'b00;
        SelALU = op;
        cyc();
        idle();
    endtask

    task automatic jumpImm(input logic [3:0] t);
        loadIr({4'h7, t});
        LoadPC = 1'b1;
        SelPC = 1'b1;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        idle();
        InstrData = 8'h00;
        CLB = 1'b0;
        #3;
        checks++;
        if ({PCAddr, Opcode, AccOut, Z, C} !== {4'h0, 4'h0, 4'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL por_state got pc=%h op=%h acc=%h z=%b c=%b", PCAddr, Opcode, AccOut, Z, C);
        end
        cyc();
        CLB = 1'b1;
        cyc();
        ldi(4'h7);
        jumpImm(4'h9);
        checks++;
        if (PCAddr !== 4'h9 || AccOut !== 4'h7) begin
            errors++;
            $display("FAIL pre_reset got pc=%h acc=%h want 9/7", PCAddr, AccOut);
        end
        #2;
        CLB = 1'b0;
        IncPC = 1'b1;
        LoadAcc = 1'b1;
        SelAcc = 2'b10;
        LoadIR = 1'b1;
        InstrData = 8'hD6;
        #1;
        checks++;
        if ({PCAddr, Opcode, AccOut, Z, C} !== {4'h0, 4'h0, 4'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got pc=%h op=%h acc=%h z=%b c=%b", PCAddr, Opcode, AccOut, Z, C);
        end
        cyc();
        cyc();
        checks++;
        if ({PCAddr, Opcode, AccOut} !== 12'h000) begin
            errors++;
            $display("FAIL reset_hold got pc=%h op=%h acc=%h want 0", PCAddr, Opcode, AccOut);
        end
        CLB = 1'b1;
        idle();
        IncPC = 1'b1;
        cyc();
        cyc();
        cyc();
        idle();
        checks++;
        if (PCAddr !== 4'h3) begin
            errors++;
            $display("FAIL inc_after_reset got pc=%h want 3", PCAddr);
        end
    endtask

    task automatic test_imm_store();
        loadIr(8'hD5);
        LoadAcc = 1'b1;
        SelAcc = 2'b10;
        cyc();
        idle();
        checks++;
        if (Opcode !== 4'hD || AccOut !== 4'h5 || Z !== 1'b0) begin
            errors++;
            $display("FAIL ldi got op=%h acc=%h z=%b want D/5/0", Opcode, AccOut, Z);
        end
        str(4'h3);
        ldi(4'h0);
        checks++;
        if (Z !== 1'b1) begin
            errors++;
            $display("FAIL z_zero got z=%b want 1", Z);
        end
        loadIr(8'h43);
        LoadAcc = 1'b1;
        SelAcc = 2'b01;
        cyc();
        idle();
        checks++;
        if (AccOut !== 4'h5 || Opcode !== 4'h4) begin
            errors++;
            $display("FAIL ldr_r3 got acc=%h op=%h want 5/4", AccOut, Opcode);
        end
    endtask

    task automatic test_add_sub();
        ldi(4'h9);
        str(4'h3);
        loadIr(8'h13);
        aluOp(4'b0000);
        checks++;
        if (AccOut !== 4'h2 || C !== 1'b1) begin
            errors++;
            $display("FAIL add_carry got acc=%h c=%b want 2/1", AccOut, C);
        end
        ldi(4'h5);
        str(4'h2);
        ldi(4'h3);
        loadIr(8'h22);
        aluOp(4'b0001);
        checks++;
        if (AccOut !== 4'hE || C !== 1'b1) begin
            errors++;
            $display("FAIL sub_borrow got acc=%h c=%b want E/1", AccOut, C);
        end
        ldi(4'h5);
        loadIr(8'h22);
        aluOp(4'b0001);
        checks++;
        if (AccOut !== 4'h0 || Z !== 1'b1 || C !== 1'b0) begin
            errors++;
            $display("FAIL sub_zero got acc=%h z=%b c=%b want 0/1/0", AccOut, Z, C);
        end
        ldi(4'h3);
        str(4'h4);
        ldi(4'h4);
        loadIr(8'h14);
        aluOp(4'b0000);
        checks++;
        if (AccOut !== 4'h7 || C !== 1'b0) begin
            errors++;
            $display("FAIL add_nocarry got acc=%h c=%b want 7/0", AccOut, C);
        end
    endtask

    task automatic test_jumps();
        loadIr(8'h7A);
        LoadPC = 1'b1;
        SelPC = 1'b1;
        IncPC = 1'b1;
        cyc();
        idle();
        checks++;
        if (PCAddr !== 4'hA) begin
            errors++;
            $display("FAIL jump_priority got pc=%h want A", PCAddr);
        end
        cyc();
        checks++;
        if (PCAddr !== 4'hA) begin
            errors++;
            $display("FAIL pc_hold got pc=%h want A", PCAddr);
        end
        ldi(4'h7);
        str(4'h2);
        loadIr(8'h62);
        LoadPC = 1'b1;
        SelPC = 1'b0;
        cyc();
        idle();
        checks++;
        if (PCAddr !== 4'h7) begin
            errors++;
            $display("FAIL jump_reg got pc=%h want 7", PCAddr);
        end
        jumpImm(4'hF);
        IncPC = 1'b1;
        cyc();
        idle();
        checks++;
        if (PCAddr !== 4'h0) begin
            errors++;
            $display("FAIL pc_wrap got pc=%h want 0", PCAddr);
        end
    endtask

    task automatic test_shr_nor_pass();
        ldi(4'hB);
        aluOp(4'b0011);
        checks++;
        if (AccOut !== 4'h5 || C !== 1'b1) begin
            errors++;
            $display("FAIL shr got acc=%h c=%b want 5/1", AccOut, C);
        end
        ldi(4'h0);
        str(4'h0);
        ldi(4'h5);
        loadIr(8'h30);
        aluOp(4'b0010);
        checks++;
        if (AccOut !== 4'hA || C !== 1'b1) begin
            errors++;
            $display("FAIL nor got acc=%h c=%b want A/1", AccOut, C);
        end
        aluOp(4'b0111);
        checks++;
        if (AccOut !== 4'hA || C !== 1'b1) begin
            errors++;
            $display("FAIL pass_op got acc=%h c=%b want A/1", AccOut, C);
        end
        LoadAcc = 1'b1;
        SelAcc = 2'b11;
        SelALU = 4'b0000;
        cyc();
        idle();
        checks++;
        if (AccOut !== 4'hA || C !== 1'b1) begin
            errors++;
            $display("FAIL acc_hold got acc=%h c=%b want A/1", AccOut, C);
        end
        ldi(4'h4);
        aluOp(4'b0011);
        checks++;
        if (AccOut !== 4'h2 || C !== 1'b0) begin
            errors++;
            $display("FAIL shr_even got acc=%h c=%b want 2/0", AccOut, C);
        end
    endtask

    task automatic test_back_to_back();
        ldi(4'h4);
        loadIr(8'h59);
        LoadReg = 1'b1;
        LoadAcc = 1'b1;
        SelAcc = 2'b10;
        cyc();
        idle();
        checks++;
        if (AccOut !== 4'h9) begin
            errors++;
            $display("FAIL reg_acc_acc got acc=%h want 9", AccOut);
        end
        ldi(4'h0);
        loadIr(8'h49);
        LoadAcc = 1'b1;
        SelAcc = 2'b01;
        cyc();
        idle();
        checks++;
        if (AccOut !== 4'h4) begin
            errors++;
            $display("FAIL reg_acc_reg got r9=%h want 4", AccOut);
        end
        loadIr(8'hD3);
        InstrData = 8'hD6;
        LoadIR = 1'b1;
        LoadAcc = 1'b1;
        SelAcc = 2'b10;
        cyc();
        idle();
        checks++;
        if (AccOut !== 4'h3) begin
            errors++;
            $display("FAIL ir_acc_old got acc=%h want 3", AccOut);
        end
        LoadAcc = 1'b1;
        SelAcc = 2'b10;
        cyc();
        idle();
        checks++;
        if (AccOut !== 4'h6) begin
            errors++;
            $display("FAIL ir_acc_new got acc=%h want 6", AccOut);
        end
    endtask

    initial begin
        test_reset();
        test_imm_store();
        test_add_sub();
        test_jumps();
        test_shr_nor_pass();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
